// File: rtl/mmio_master.sv
// MMIO bus initiator: one outstanding load/store sequenced SETUP -> ACCESS x ACCESS_CYCLES -> HOLD.
// Latency ACCESS_CYCLES+2 cycles to resp_valid; req_ready low while busy, so requests stall upstream.
module mmio_master #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_req_write,
  input  logic [63:0] i_req_address,
  input  logic [63:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_rdata,
  output logic [63:0] o_address,
  inout  wire  [63:0] io_data,
  output logic        o_read,
  output logic        o_write
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_is_write;
  logic        r_drive;
  logic        r_read;
  logic        r_write;
  logic        r_resp_valid;
  logic [63:0] r_address;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        w_accept;

  assign w_accept = i_req && (r_state == S_IDLE);

  // Strobes, address and data enable are registered so bus-side decoders never see decode glitches.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_is_write   <= 1'b0;
      r_drive      <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_address    <= 64'd0;
      r_rdata      <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_SETUP;
            r_is_write <= i_req_write;
            r_drive    <= i_req_write;
            r_address  <= i_req_address;
            r_cnt      <= CNT_INIT;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_read  <= !r_is_write;
          r_write <= r_is_write;
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_HOLD;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b1;
            // Only the value present at the end of the final access cycle is taken.
            if (!r_is_write) r_rdata <= io_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_drive      <= 1'b0;
          r_address    <= 64'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store data only reaches the bus while r_drive is set, so it needs no reset.
  always_ff @(posedge i_clock) begin
    if (i_reset && w_accept) r_wdata <= i_req_wdata;
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_address    = r_address;
  assign o_read       = r_read;
  assign o_write      = r_write;
  assign io_data      = r_drive ? r_wdata : 64'bz;

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: reset, store, load, back-to-back, mid-access reset, long access.
module tb_mmio_master;

  localparam logic [63:0] A_ST   = 64'h0500_0000_0000_0001;
  localparam logic [63:0] W_ST   = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] A_LD   = 64'h0500_0000_0000_0010;
  localparam logic [63:0] V_LOAD = {19'b0, 10'h2AA, 3'b101, 32'hDEAD_BEEF};
  localparam logic [63:0] V_B1   = 64'h0500_1111_2222_3333;
  localparam logic [63:0] V_B2   = 64'h0A0B_4444_5555_6666;
  localparam logic [63:0] A_ST2  = 64'h0500_0000_0000_0040;
  localparam logic [63:0] W_ST2  = 64'hCAFE_F00D_0000_1111;
  localparam logic [63:0] V_C    = 64'h0500_ABCD_0000_0001;

  logic        clk;
  logic        rst_n;
  logic        req, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        ready, rv, rd, wr;
  logic [63:0] rdata, addr;
  wire  [63:0] bus;

  logic        req2;
  logic [63:0] req2_addr, req2_wdata;
  logic        ready2, rv2, rd2, wr2;
  logic [63:0] rdata2, addr2;
  wire  [63:0] bus2;
  logic [63:0] bus2_val;

  logic        keep, model_en;
  logic [63:0] rval;
  logic [63:0] cap;
  logic [63:0] mdl_rdata;
  logic [63:0] sb[$];
  int          checks, errors, pulses, pulses0;

  // Bus peripheral model: answers loads to region 0x05, otherwise optionally holds the bus at 0.
  assign bus  = (model_en && rd && addr[63:56] == 8'h05) ? rval : (keep ? 64'h0 : 64'bz);
  assign bus2 = bus2_val;

  mmio_master #(.ACCESS_CYCLES(2)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_req(req), .i_req_write(req_write),
    .i_req_address(req_addr), .i_req_wdata(req_wdata), .o_req_ready(ready),
    .o_resp_valid(rv), .o_resp_rdata(rdata), .o_address(addr), .io_data(bus),
    .o_read(rd), .o_write(wr)
  );

  mmio_master #(.ACCESS_CYCLES(4)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_req(req2), .i_req_write(1'b0),
    .i_req_address(req2_addr), .i_req_wdata(req2_wdata), .o_req_ready(ready2),
    .o_resp_valid(rv2), .o_resp_rdata(rdata2), .o_address(addr2), .io_data(bus2),
    .o_read(rd2), .o_write(wr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (wr) cap <= bus;

  always @(negedge clk) begin
    if (rv) begin
      pulses++;
      if (sb.size() == 0) chk("sb_unexpected_resp", 64'(sb.size()), 64'd1);
      else chk("sb_rdata", rdata, sb.pop_front());
    end
  end

  task automatic do_load(input string tag, input logic [63:0] a, input logic [63:0] v);
    req = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = '1; rval = v;
    keep = 1'b1; mdl_rdata = v; sb.push_back(v);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk({tag, "_read"},  64'(rd), 64'(j == 2 || j == 3));
      chk({tag, "_write"}, 64'(wr), 64'd0);
      chk({tag, "_rv"},    64'(rv), 64'(j == 4));
      chk({tag, "_bus"},   bus, (j == 2 || j == 3) ? v : 64'h0);
      if (j >= 4) chk({tag, "_rdata"}, rdata, v);
      if (j == 1) begin req = 1'b0; req_addr = '0; end
    end
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0; mdl_rdata = '0; cap = '0;
    rst_n = 1'b0; req = 1'b1; req_write = 1'b0; req_addr = A_LD; req_wdata = '1;
    keep = 1'b1; model_en = 1'b1; rval = V_LOAD;
    req2 = 1'b0; req2_addr = 64'h0500_0000_0000_0020; req2_wdata = '1; bus2_val = 64'h1;

    // Reset held with a pending request
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_read",  64'(rd), 64'd0);
      chk("rst_write", 64'(wr), 64'd0);
      chk("rst_bus",   bus, 64'h0);
      chk("rst_addr",  addr, 64'h0);
      chk("rst_rv",    64'(rv), 64'd0);
      chk("rst_rdata", rdata, 64'h0);
    end
    req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'd1);
    chk("post_rst_read",  64'(rd), 64'd0);

    // Store; request inputs scrambled after acceptance
    keep = 1'b0; req = 1'b1; req_write = 1'b1; req_addr = A_ST; req_wdata = W_ST;
    sb.push_back(mdl_rdata);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("st_write", 64'(wr), 64'(j == 2 || j == 3));
      chk("st_read",  64'(rd), 64'd0);
      chk("st_rv",    64'(rv), 64'(j == 4));
      chk("st_ready", 64'(ready), 64'(j == 5));
      chk("st_addr",  addr, (j <= 4) ? A_ST : 64'h0);
      chk("st_bus",   bus, (j <= 4) ? W_ST : 64'h0);
      if (j == 1) begin req = 1'b0; req_write = 1'b0; req_addr = '1; req_wdata = '0; end
      if (j == 4) keep = 1'b1;
    end
    chk("st_capture", cap, W_ST);
    chk("st_rdata_kept", rdata, 64'h0);

    do_load("ld", A_LD, V_LOAD);

    // Back-to-back loads with req held high
    req = 1'b1; req_write = 1'b0; req_addr = A_LD; rval = V_B1;
    mdl_rdata = V_B1; sb.push_back(V_B1); pulses0 = pulses;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("b2b_ready", 64'(ready), 64'(j == 5 || j == 10));
      chk("b2b_rv",    64'(rv), 64'(j == 4 || j == 9));
      chk("b2b_read",  64'(rd), 64'(j == 2 || j == 3 || j == 7 || j == 8));
      if (j == 9) chk("b2b_rdata2", rdata, V_B2);
      if (j == 5) begin rval = V_B2; mdl_rdata = V_B2; sb.push_back(V_B2); end
      if (j == 10) req = 1'b0;
    end
    chk("b2b_pulses", 64'(pulses - pulses0), 64'd2);

    // Reset during a store abandons it silently
    keep = 1'b0; req = 1'b1; req_write = 1'b1; req_addr = A_ST2; req_wdata = W_ST2;
    sb.push_back(mdl_rdata); pulses0 = pulses;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) req = 1'b0;
      if (j == 2) begin
        chk("abort_write_pre", 64'(wr), 64'd1);
        chk("abort_bus_pre", bus, W_ST2);
        rst_n = 1'b0; keep = 1'b1; sb.delete(); mdl_rdata = '0;
      end else if (j == 3) begin
        chk("abort_write", 64'(wr), 64'd0);
        chk("abort_bus",   bus, 64'h0);
        chk("abort_addr",  addr, 64'h0);
        chk("abort_rdata", rdata, 64'h0);
        chk("abort_ready", 64'(ready), 64'd1);
        rst_n = 1'b1;
      end
      if (j >= 3) chk("abort_rv", 64'(rv), 64'd0);
    end
    chk("abort_pulses", 64'(pulses - pulses0), 64'd0);
    do_load("ld_after_rst", A_LD, V_C);

    // Four-cycle access: bus value changes after the first access cycle
    req2 = 1'b1; bus2_val = 64'h1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk("n4_read",  64'(rd2), 64'(j >= 2 && j <= 5));
      chk("n4_write", 64'(wr2), 64'd0);
      chk("n4_rv",    64'(rv2), 64'(j == 6));
      chk("n4_ready", 64'(ready2), 64'(j == 7));
      if (j == 5) chk("n4_no_early_capture", rdata2, 64'h0);
      if (j == 6) chk("n4_rdata", rdata2, 64'h2);
      if (j == 1) req2 = 1'b0;
      if (j == 2) bus2_val = 64'h2;
    end

    repeat (3) @(negedge clk);
    chk("total_pulses", 64'(pulses), 64'd5);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
